fillrect: RTL
=============

Name: fillrect

Overview:
- Parametrised rectangle-fill engine that drives the VGA adapter pixel-write interface (vga_x, vga_y, vga_colour, vga_plot).
- Plots one pixel per clock over a caller-supplied rectangle (x0, y0, w, h) in a caller-supplied colour.
- Clips the rectangle to the screen and reports completion with a start/done handshake.
- Generalises the fixed full-screen fill: any screen size, any sub-rectangle, selectable colour, empty-region handling, optional two-colour checker pattern.

Parameters:
SCREEN_W, 160, screen width in pixels
SCREEN_H, 120, screen height in pixels
XW, 8, vga_x / x0 width; must satisfy 2^XW >= SCREEN_W
YW, 7, vga_y / y0 width; must satisfy 2^YW >= SCREEN_H
CW, 3, colour width

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  request; sampled only in IDLE
x0  in  XW  rectangle left column
y0  in  YW  rectangle top row
w  in  XW+1  rectangle width in pixels (0 allowed)
h  in  YW+1  rectangle height in pixels (0 allowed)
colour  in  CW  fill colour
done  out  1  operation complete; held until start drops
busy  out  1  high in FILL
vga_x  out  XW  pixel column
vga_y  out  YW  pixel row
vga_colour  out  CW  pixel colour
vga_plot  out  1  pixel write strobe

Behaviour:
- Reset (async, rst_n=0): state=IDLE; done=0, busy=0, vga_plot=0, vga_x=0, vga_y=0, vga_colour=0. Reset mid-fill aborts immediately; no further plots; no done.
- States: IDLE, FILL, DONE.
- IDLE:
  - start=1 at edge N latches x0, y0, colour.
  - Computes xe=min(x0+w, SCREEN_W) and ye=min(y0+h, SCREEN_H) using XW+1 / YW+1 bit arithmetic; no wrap.
  - If xe<=x0 or ye<=y0 (covers w=0, h=0, x0>=SCREEN_W, y0>=SCREEN_H): go to DONE; done=1 visible after edge N; zero plots.
  - Otherwise: go to FILL with vga_x=x0, vga_y=y0, vga_plot=1, busy=1 after edge N.
- FILL:
  - Registered outputs; vga_plot=1 every cycle; exactly (xe-x0)*(ye-y0) plot cycles.
  - Column-major order: y increments each cycle.
  - At y=ye-1: y returns to y0 and x increments.
  - At (xe-1, ye-1): next edge goes to DONE with vga_plot=0, busy=0, done=1.
  - vga_x/vga_y hold their last value outside FILL.
  - start and all rectangle inputs are ignored during FILL; only the latched copies are used.
- DONE: done=1 while start=1. When start=0, done=0 on the next edge and state returns to IDLE.
- Start pulses shorter than one IDLE cycle are not required to be caught.
- Back-to-back fills: start must drop (at least one cycle in DONE with start=0) before a new request is accepted.

Optional Feature:
- Macro: FILLRECT_CHECKER_EN.
- Defined:
  - Adds input colour_b [CW] and input checker (1 bit); both latched at start.
  - When latched checker=1, a pixel with (vga_x[0]^vga_y[0])==1 gets colour_b; all other pixels get colour.
  - When latched checker=0, every pixel gets colour.
- Undefined: colour_b and checker ports are absent; every pixel gets colour.

Test Plan:
- Full screen: x0=0, y0=0, w=160, h=120, colour=3'b111, start held.
  -> Exactly 19200 plot cycles, first pixel (0,0), last pixel (159,119), (0,119) followed by (1,0); done=1 the cycle after the last plot.
- Clipping: x0=150, y0=110, w=20, h=20, colour=3'b010.
  -> 100 plots covering x 150..159 and y 110..119 only; no plot with x>159 or y>119.
- Empty: w=0 (then separately x0=200) with start.
  -> vga_plot never asserts; done=1 one cycle after start is sampled.
- Handshake: after done, hold start 5 cycles -> done stays 1, no plots. Drop start -> done=0 next cycle. New request x0=3, y0=4, w=2, h=2 -> plots (3,4), (3,5), (4,4), (4,5).
- Reset mid-fill: assert rst_n=0 on the 50th plot of a full-screen fill.
  -> All outputs 0 immediately; after release, state is IDLE with no plots and done=0 until the next start.
- FILLRECT_CHECKER_EN: x0=0, y0=0, w=2, h=2, colour=1, colour_b=6, checker=1.
  -> Colours 1, 6, 6, 1 for (0,0), (0,1), (1,0), (1,1).

Source files
------------

// File: rtl/fillrect.sv
// fillrect: rectangle-fill engine driving the VGA adapter pixel-write port.
//
// Plots one pixel per clock over the rectangle (x0, y0, w, h), clipped to
// SCREEN_W x SCREEN_H, in column-major order (y is the fast index).
//
// Optional feature, enabled by defining FILLRECT_CHECKER_EN:
//   adds colour_b and checker_on inputs. When checker_on was high at start,
//   pixels with x[0]^y[0]==1 take colour_b, all others take colour.
//   The mode input is called checker_on because "checker" is a reserved
//   SystemVerilog keyword.
//
// Handshake: start is sampled only in IDLE. done rises when the fill is
// complete (or immediately for an empty/off-screen rectangle) and holds
// while start stays high; dropping start returns the engine to IDLE.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start             fill request (sampled in IDLE only)
//   x0, y0            rectangle top-left corner
//   w, h              rectangle size in pixels (0 allowed)
//   colour            fill colour
//   colour_b          second checker colour   (FILLRECT_CHECKER_EN only)
//   checker_on        checker pattern enable  (FILLRECT_CHECKER_EN only)
//   done              operation complete, held until start drops
//   busy              high while filling
//   vga_x, vga_y      pixel coordinate
//   vga_colour        pixel colour
//   vga_plot          pixel write strobe
module fillrect #(
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120,
    parameter int XW       = 8,
    parameter int YW       = 7,
    parameter int CW       = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [XW-1:0] x0,
    input  logic [YW-1:0] y0,
    input  logic [XW:0]   w,
    input  logic [YW:0]   h,
    input  logic [CW-1:0] colour,
`ifdef FILLRECT_CHECKER_EN
    input  logic [CW-1:0] colour_b,
    input  logic          checker_on,
`endif
    output logic          done,
    output logic          busy,
    output logic [XW-1:0] vga_x,
    output logic [YW-1:0] vga_y,
    output logic [CW-1:0] vga_colour,
    output logic          vga_plot
);

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_DONE} state_t;

    state_t state, state_nxt;

    localparam logic [XW+1:0] SW_WIDE = (XW+2)'(SCREEN_W);
    localparam logic [YW+1:0] SH_WIDE = (YW+2)'(SCREEN_H);
    localparam logic [XW:0]   SW_END  = (XW+1)'(SCREEN_W);
    localparam logic [YW:0]   SH_END  = (YW+1)'(SCREEN_H);

    // Exclusive end coordinates, clipped to the screen. The sums are one bit
    // wider than the end registers so x0+w can never wrap before the clamp.
    logic [XW+1:0] x_sum;
    logic [YW+1:0] y_sum;
    logic [XW:0]   x_end;
    logic [YW:0]   y_end;
    logic          rect_empty;

    assign x_sum      = {2'b00, x0} + {1'b0, w};
    assign y_sum      = {2'b00, y0} + {1'b0, h};
    assign x_end      = (x_sum > SW_WIDE) ? SW_END : x_sum[XW:0];
    assign y_end      = (y_sum > SH_WIDE) ? SH_END : y_sum[YW:0];
    assign rect_empty = (x_end <= {1'b0, x0}) || (y_end <= {1'b0, y0});

    // Latched request
    logic [YW-1:0] y0_q;
    logic [XW:0]   x_end_q;
    logic [YW:0]   y_end_q;
    logic [CW-1:0] colour_q;
`ifdef FILLRECT_CHECKER_EN
    logic [CW-1:0] colour_b_q;
    logic          checker_q;
`endif

    logic last_row, last_col;
    assign last_row = ({1'b0, vga_y} + (YW+1)'(1)) == y_end_q;
    assign last_col = ({1'b0, vga_x} + (XW+1)'(1)) == x_end_q;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (start)                state_nxt = rect_empty ? S_DONE : S_FILL;
            S_FILL: if (last_row && last_col) state_nxt = S_DONE;
            S_DONE: if (!start)               state_nxt = S_IDLE;
            default:                          state_nxt = S_IDLE;
        endcase
    end

    // Coordinate scan and request latch. On the final pixel the coordinate
    // is left alone so vga_x/vga_y keep the last plotted position.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vga_x      <= '0;
            vga_y      <= '0;
            y0_q       <= '0;
            x_end_q    <= '0;
            y_end_q    <= '0;
            colour_q   <= '0;
`ifdef FILLRECT_CHECKER_EN
            colour_b_q <= '0;
            checker_q  <= 1'b0;
`endif
        end else if (state == S_IDLE) begin
            if (start && !rect_empty) begin
                vga_x      <= x0;
                vga_y      <= y0;
                y0_q       <= y0;
                x_end_q    <= x_end;
                y_end_q    <= y_end;
                colour_q   <= colour;
`ifdef FILLRECT_CHECKER_EN
                colour_b_q <= colour_b;
                checker_q  <= checker_on;
`endif
            end
        end else if (state == S_FILL) begin
            if (last_row) begin
                if (!last_col) begin
                    vga_y <= y0_q;
                    vga_x <= vga_x + XW'(1);
                end
            end else begin
                vga_y <= vga_y + YW'(1);
            end
        end
    end

    // Outputs: all derived from registered state, so glitch-free per cycle
    always_comb begin
        busy     = (state == S_FILL);
        vga_plot = (state == S_FILL);
        done     = (state == S_DONE);
`ifdef FILLRECT_CHECKER_EN
        vga_colour = (checker_q && (vga_x[0] ^ vga_y[0])) ? colour_b_q : colour_q;
`else
        vga_colour = colour_q;
`endif
    end

endmodule
